// File: rtl/axis_frame_len_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_len_check_pkg
// Purpose  : Shared types and helpers for the AXI-stream frame-length policer.
// Revision : 1.0 - initial release
// ============================================================================
package axis_frame_len_check_pkg;

  // Policer states: forwarding a frame, or dropping the tail of an oversize one
  typedef enum logic [0:0] {
    PASS    = 1'b0,
    DISCARD = 1'b1
  } state_t;

  // tuser bit that carries the bad-frame flag towards the frame FIFO
  localparam int TUSER_BAD_BIT = 0;

  // Widest tkeep the popcount helper handles; callers zero-extend into it
  localparam int KEEP_MAX = 64;

  // Number of valid bytes in a beat
  function automatic int unsigned popcount_keep(input logic [KEEP_MAX-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      n = n + 32'(keep[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_len_check_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_len_check_if
// Purpose  : AXI-stream bundle (tdata/tkeep/tvalid/tready/tlast/tuser).
// Revision : 1.0 - initial release
// ============================================================================
interface axis_frame_len_check_if #(
  parameter int DATA_BYTES = 8,
  parameter int USER_WIDTH = 1
);
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_frame_len_check_reg_skid.sv
`default_nettype none
// ============================================================================
// Module   : axis_reg_skid
// Purpose  : One-stage registered stream slice with a skid register. in_ready
//            is a flop, so no combinational path runs from out_ready to
//            in_ready, and full throughput is kept while out_ready is high.
// Revision : 1.0 - initial release
// ============================================================================
module axis_reg_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             r_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_accept;
  logic             w_load;
  logic             w_skid_next;

  // Output register may take new data when empty or being consumed; the skid
  // fills only when a beat is accepted while the output is stalled
  always_comb begin
    w_accept    = in_valid & r_ready;
    w_load      = out_ready | ~r_out_valid;
    w_skid_next = w_load ? 1'b0 : (r_skid_valid | w_accept);
  end

  // Output/skid registers; ready is the registered "skid will be empty"
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_ready      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else begin
      if (w_load) begin
        if (r_skid_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_skid_data;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept) r_out_data <= in_data;
        end
      end else if (w_accept) begin
        r_skid_data <= in_data;
      end
      r_skid_valid <= w_skid_next;
      r_ready      <= ~w_skid_next;
    end
  end

  assign in_ready  = r_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: rtl/axis_frame_len_check.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_len_check
// Purpose  : Inline AXI-stream frame-length policer. Flags runt frames and
//            truncates oversize frames (forced tlast + bad flag) so a
//            downstream drop-bad-frame FIFO discards them.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_len_check
  import axis_frame_len_check_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int USER_WIDTH = 1,
  parameter int MIN_BYTES  = 64,
  parameter int MAX_BYTES  = 1518,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  async_rst,
  axis_frame_len_check_if.slave  s_axis,
  axis_frame_len_check_if.master m_axis,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] runt_count,
  output logic [STAT_WIDTH-1:0] oversize_count,
  output logic                  frame_good
);

  localparam int CNT_W   = $clog2(MAX_BYTES + DATA_BYTES + 1);
  localparam int SLICE_W = 8*DATA_BYTES + DATA_BYTES + 1 + USER_WIDTH;

  // Parameter sanity checks
  if (MIN_BYTES < 1 || MIN_BYTES > MAX_BYTES) begin : g_chk_limits
    $error("axis_frame_len_check: need 1 <= MIN_BYTES <= MAX_BYTES");
  end
  if (DATA_BYTES < 1 || DATA_BYTES > KEEP_MAX) begin : g_chk_data
    $error("axis_frame_len_check: DATA_BYTES out of range");
  end
  if (USER_WIDTH < 1) begin : g_chk_user
    $error("axis_frame_len_check: USER_WIDTH must be >= 1");
  end

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_byte_cnt, w_byte_cnt_next;
  logic [CNT_W-1:0]      w_beat_bytes, w_sum;
  logic [KEEP_MAX-1:0]   w_keep_ext;
  logic                  w_over, w_runt, w_accept;
  logic                  w_slice_valid, w_slice_ready, w_out_valid;
  logic                  w_out_last;
  logic [USER_WIDTH-1:0] w_out_user;
  logic                  w_inc_runt, w_inc_over, w_good;
  logic [SLICE_W-1:0]    w_slice_in, w_slice_out;

  // In DISCARD the input is always ready since dropped beats never reach the slice
  assign s_axis.tready = (r_state == DISCARD) | w_slice_ready;
  assign w_accept      = s_axis.tvalid & s_axis.tready;

  // Next-state, byte count and policed beat fields
  always_comb begin
    w_keep_ext                 = '0;
    w_keep_ext[DATA_BYTES-1:0] = s_axis.tkeep;
    w_beat_bytes    = CNT_W'(popcount_keep(w_keep_ext));
    w_sum           = r_byte_cnt + w_beat_bytes;
    w_over          = w_sum > CNT_W'(MAX_BYTES);
    w_runt          = w_sum < CNT_W'(MIN_BYTES);
    w_state_next    = r_state;
    w_byte_cnt_next = r_byte_cnt;
    w_out_last      = s_axis.tlast;
    w_out_user      = s_axis.tuser;
    w_slice_valid   = 1'b0;
    w_inc_runt      = 1'b0;
    w_inc_over      = 1'b0;
    w_good          = 1'b0;
    case (r_state)
      PASS: begin
        w_slice_valid = s_axis.tvalid;
        if (w_over) begin
          w_out_last                = 1'b1;
          w_out_user[TUSER_BAD_BIT] = 1'b1;
        end else if (s_axis.tlast) begin
          w_out_user[TUSER_BAD_BIT] = s_axis.tuser[TUSER_BAD_BIT] | w_runt;
        end
        if (w_accept) begin
          if (w_over) begin
            // Length limit wins over the runt check
            w_inc_over      = 1'b1;
            w_byte_cnt_next = '0;
            if (!s_axis.tlast) w_state_next = DISCARD;
          end else if (s_axis.tlast) begin
            w_inc_runt      = w_runt;
            w_good          = ~w_out_user[TUSER_BAD_BIT];
            w_byte_cnt_next = '0;
          end else begin
            w_byte_cnt_next = w_sum;
          end
        end
      end
      DISCARD: begin
        if (w_accept && s_axis.tlast) begin
          w_state_next    = PASS;
          w_byte_cnt_next = '0;
        end
      end
      default: begin
        w_state_next    = PASS;
        w_byte_cnt_next = '0;
      end
    endcase
  end

  // FSM state and running byte count
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state    <= PASS;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_byte_cnt <= w_byte_cnt_next;
    end
  end

  // Saturating event counters (clear beats increment) and good-frame pulse
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      runt_count     <= '0;
      oversize_count <= '0;
      frame_good     <= 1'b0;
    end else begin
      frame_good <= w_good;
      if (stat_clear) runt_count <= '0;
      else if (w_inc_runt && runt_count != '1) runt_count <= runt_count + STAT_WIDTH'(1);
      if (stat_clear) oversize_count <= '0;
      else if (w_inc_over && oversize_count != '1) oversize_count <= oversize_count + STAT_WIDTH'(1);
    end
  end

  assign w_slice_in = {s_axis.tdata, s_axis.tkeep, w_out_last, w_out_user};

  axis_reg_skid #(
    .WIDTH (SLICE_W)
  ) u_slice (
    .clk       (clk),
    .async_rst (async_rst),
    .in_data   (w_slice_in),
    .in_valid  (w_slice_valid),
    .in_ready  (w_slice_ready),
    .out_data  (w_slice_out),
    .out_valid (w_out_valid),
    .out_ready (m_axis.tready)
  );

  assign m_axis.tvalid = w_out_valid;
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser} = w_slice_out;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_len_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_frame_len_check
// Purpose  : Self-checking bench for axis_frame_len_check with a frame-level
//            reference model and an output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_len_check;

  localparam int DB   = 8;
  localparam int UW   = 1;
  localparam int MINB = 64;
  localparam int MAXB = 1518;
  localparam int SW   = 32;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [0:0]  user;
  } beat_t;

  logic          clk = 1'b0;
  logic          async_rst = 1'b1;
  logic          stat_clear = 1'b0;
  logic [SW-1:0] runt_count, oversize_count;
  logic          frame_good;

  axis_frame_len_check_if #(.DATA_BYTES(DB), .USER_WIDTH(UW)) s_if ();
  axis_frame_len_check_if #(.DATA_BYTES(DB), .USER_WIDTH(UW)) m_if ();

  axis_frame_len_check #(
    .DATA_BYTES (DB), .USER_WIDTH (UW), .MIN_BYTES (MINB),
    .MAX_BYTES (MAXB), .STAT_WIDTH (SW)
  ) dut (
    .clk            (clk),
    .async_rst      (async_rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .stat_clear     (stat_clear),
    .runt_count     (runt_count),
    .oversize_count (oversize_count),
    .frame_good     (frame_good)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  int    exp_runt = 0, exp_over = 0, exp_good = 0, got_good = 0;
  bit    mon_en = 1'b1;
  bit    rnd_mode = 1'b0;
  bit    rdy_val = 1'b1;
  beat_t mon_e;

  // Downstream ready: fixed level or 50% random, changed just after each edge
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_if.tready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Scoreboard: every output handshake must match the next expected beat
  always @(negedge clk) begin
    if (!async_rst && mon_en) begin
      if (frame_good) got_good++;
      if (m_if.tvalid && m_if.tready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_beat: unexpected beat data=%h last=%b, required none", m_if.tdata, m_if.tlast);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_if.tdata !== mon_e.data || m_if.tkeep !== mon_e.keep ||
              m_if.tlast !== mon_e.last || m_if.tuser !== mon_e.user) begin
            n_fail++;
            $display("FAIL out_beat: got d=%h k=%h l=%b u=%b, required d=%h k=%h l=%b u=%b",
                     m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser,
                     mon_e.data, mon_e.keep, mon_e.last, mon_e.user);
          end
        end
      end
    end
  end

  // Frame-level reference: running length, truncate at the first beat that
  // exceeds MAXB, police only the final beat of a frame that fits
  function automatic void model_frame(input beat_t fr[$]);
    int total;
    beat_t b;
    total = 0;
    foreach (fr[i]) begin
      b = fr[i];
      total += $countones(b.keep);
      if (total > MAXB) begin
        b.last = 1'b1;
        b.user = 1'b1;
        exp_q.push_back(b);
        exp_over++;
        return;
      end
      if (b.last) begin
        if (total < MINB) begin
          b.user = 1'b1;
          exp_runt++;
        end
        if (b.user == 1'b0) exp_good++;
      end
      exp_q.push_back(b);
    end
  endfunction

  task automatic build_frame(input int nbytes, input int bad_pct, output beat_t fr[$]);
    int left, n;
    beat_t b;
    fr.delete();
    left = nbytes;
    while (left > 0) begin
      n = (left >= DB) ? DB : left;
      b.data = {$urandom, $urandom};
      b.keep = 8'((1 << n) - 1);
      left -= n;
      b.last = (left == 0);
      b.user = (int'($urandom_range(0, 99)) < bad_pct) ? 1'b1 : 1'b0;
      fr.push_back(b);
    end
  endtask

  // Present one beat after optional idle cycles; returns cycles spent waiting for ready
  task automatic drive_beat(input beat_t b, input int gap, output int waited);
    if (gap > 0) begin
      s_if.tvalid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = b.data;
    s_if.tkeep  = b.keep;
    s_if.tlast  = b.last;
    s_if.tuser  = b.user;
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_if.tready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 2000) begin
        n_tests++; n_fail++;
        $display("FAIL drive_timeout: ready low for %0d cycles, required accept", waited);
        break;
      end
    end
  endtask

  task automatic send_frame(input beat_t fr[$], input int gap_pct, input bit clr_last);
    int w, gap;
    model_frame(fr);
    foreach (fr[i]) begin
      gap = (int'($urandom_range(0, 99)) < gap_pct) ? int'($urandom_range(1, 2)) : 0;
      if (clr_last && fr[i].last) begin
        gap = 0;
        stat_clear = 1'b1;
      end
      drive_beat(fr[i], gap, w);
      stat_clear = 1'b0;
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 20000) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_counters(input string tag);
    n_tests++;
    if (runt_count !== 32'(exp_runt)) begin
      n_fail++;
      $display("FAIL %s runt_count: got %0d, required %0d", tag, runt_count, exp_runt);
    end
    n_tests++;
    if (oversize_count !== 32'(exp_over)) begin
      n_fail++;
      $display("FAIL %s oversize_count: got %0d, required %0d", tag, oversize_count, exp_over);
    end
    n_tests++;
    if (got_good !== exp_good) begin
      n_fail++;
      $display("FAIL %s frame_good pulses: got %0d, required %0d", tag, got_good, exp_good);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 || frame_good !== 1'b0 ||
        runt_count !== '0 || oversize_count !== '0) begin
      n_fail++;
      $display("FAIL %s: got mv=%b sr=%b fg=%b rc=%0d oc=%0d, required all 0", tag,
               m_if.tvalid, s_if.tready, frame_good, runt_count, oversize_count);
    end
  endtask

  task automatic apply_reset();
    async_rst = 1'b1;
    s_if.tvalid = 1'b0;
    #1;
    check_reset_outputs("reset_immediate");
    exp_q.delete();
    exp_runt = 0; exp_over = 0; exp_good = 0; got_good = 0;
    repeat (3) @(posedge clk);
    #1;
    async_rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (s_if.tready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, required 1", s_if.tready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    apply_reset();
  endtask

  task automatic test_basic();
    beat_t fr[$];
    build_frame(64, 0, fr);
    send_frame(fr, 0, 1'b0);
    wait_drain();
    n_tests++;
    if (got_good !== 1) begin
      n_fail++;
      $display("FAIL basic frame_good: got %0d pulses, required 1", got_good);
    end
    check_counters("basic");
  endtask

  task automatic test_runt();
    beat_t fr[$];
    build_frame(60, 0, fr);
    send_frame(fr, 0, 1'b0);
    wait_drain();
    n_tests++;
    if (runt_count !== 32'd1) begin
      n_fail++;
      $display("FAIL runt count: got %0d, required 1", runt_count);
    end
    check_counters("runt");
  endtask

  task automatic test_oversize();
    beat_t fr[$];
    int w;
    build_frame(1600, 0, fr);
    model_frame(fr);
    for (int i = 0; i < 190; i++) drive_beat(fr[i], 0, w);
    rdy_val = 1'b0;
    for (int i = 190; i < 200; i++) begin
      drive_beat(fr[i], 0, w);
      n_tests++;
      if (w !== 0) begin
        n_fail++;
        $display("FAIL discard_ready beat %0d: waited %0d cycles, required 0", i, w);
      end
    end
    s_if.tvalid = 1'b0;
    rdy_val = 1'b1;
    wait_drain();
    check_counters("oversize");
    build_frame(64, 0, fr);
    send_frame(fr, 0, 1'b0);
    wait_drain();
    check_counters("after_oversize");
  endtask

  task automatic test_exact();
    beat_t fr[$];
    build_frame(MAXB, 0, fr);     send_frame(fr, 0, 1'b0);
    build_frame(MINB, 0, fr);     send_frame(fr, 0, 1'b0);
    build_frame(MAXB + 1, 0, fr); send_frame(fr, 0, 1'b0);
    build_frame(MINB, 0, fr);     send_frame(fr, 0, 1'b0);
    build_frame(MINB - 1, 0, fr); send_frame(fr, 0, 1'b0);
    wait_drain();
    check_counters("exact");
  endtask

  task automatic test_stat_clear();
    beat_t fr[$];
    build_frame(60, 0, fr);
    send_frame(fr, 0, 1'b1);
    wait_drain();
    exp_runt = 0;
    exp_over = 0;
    check_counters("stat_clear");
  endtask

  task automatic test_random();
    beat_t fr[$];
    int r, len;
    rnd_mode = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      r = int'($urandom_range(0, 99));
      if (r < 47)      len = int'($urandom_range(1, 70));
      else if (r < 94) len = int'($urandom_range(71, 200));
      else if (r < 97) len = int'($urandom_range(1510, 1530));
      else             len = int'($urandom_range(1531, 1600));
      build_frame(len, 5, fr);
      send_frame(fr, 20, 1'b0);
    end
    rnd_mode = 1'b0;
    wait_drain();
    check_counters("random");
  endtask

  task automatic test_reset_mid();
    beat_t fr[$];
    int w;
    // Mid-frame: partial frame outside the model, then reset
    mon_en = 1'b0;
    build_frame(64, 0, fr);
    for (int i = 0; i < 3; i++) drive_beat(fr[i], 0, w);
    apply_reset();
    build_frame(64, 0, fr);
    send_frame(fr, 0, 1'b0);
    wait_drain();
    check_counters("reset_midframe");
    // Mid-discard: oversize frame cut off while tail is being dropped
    mon_en = 1'b0;
    build_frame(1600, 0, fr);
    for (int i = 0; i < 195; i++) drive_beat(fr[i], 0, w);
    apply_reset();
    build_frame(64, 0, fr);
    send_frame(fr, 0, 1'b0);
    wait_drain();
    check_counters("reset_middiscard");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_runt();
    test_oversize();
    test_exact();
    test_stat_clear();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #950_000;
    n_fail++;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
